complex_frame_serializer: RTL and testbench

Parametrised successor to the fixed 4-to-1 complex selector in the FFT datapath. Captures one frame of N_CH complex samples in parallel, then streams them out one per accepted beat under a valid/ready handshake, in natural or bit-reversed channel order. It sits between a butterfly stage's parallel outputs and the serial output/reorder path of the FFT.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/complex_frame_serializer_if.sv | 31 +++
 rtl/mux_n_complex.sv | 27 ++
 rtl/complex_frame_serializer.sv | 103 ++++++++++
 tb/tb_complex_frame_serializer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default word size, serializer state type,
// and the bit-reversal helper used for reordered channel selection.
package fft_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int MAX_SEL_W     = 6;   // supports up to 64 channels

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Reverses the low 'width' bits of value; bits above 'width' come back zero.
  function automatic logic [MAX_SEL_W-1:0] bit_reverse(
    input logic [MAX_SEL_W-1:0] value,
    input int                   width
  );
    logic [MAX_SEL_W-1:0] full_rev;
    full_rev = '0;
    for (int i = 0; i < MAX_SEL_W; i++) begin
      full_rev[i] = value[MAX_SEL_W-1-i];
    end
    return full_rev >> (MAX_SEL_W - width);
  endfunction

endpackage

// File: rtl/complex_frame_serializer_if.sv
// Parallel-frame input / serial-beat output bundle of the complex frame serializer.
// The master drives frames and consumes beats; the slave is the serializer.
interface complex_frame_serializer_if #(
  parameter int WORD_SIZE = fft_pkg::WORD_SIZE_DEF,
  parameter int N_CH      = 4
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*WORD_SIZE-1:0] in_re;
  logic [N_CH*WORD_SIZE-1:0] in_im;
  logic                      in_valid;
  logic                      in_ready;
  logic                      bitrev;
  logic [WORD_SIZE-1:0]      out_re;
  logic [WORD_SIZE-1:0]      out_im;
  logic [SEL_W-1:0]          out_idx;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;

  modport master (
    output in_re, in_im, in_valid, bitrev, out_ready,
    input  in_ready, out_re, out_im, out_idx, out_valid, out_last
  );

  modport slave (
    input  in_re, in_im, in_valid, bitrev, out_ready,
    output in_ready, out_re, out_im, out_idx, out_valid, out_last
  );

endinterface

// File: rtl/mux_n_complex.sv
// Combinational N_CH-to-1 complex sample selector over packed channel vectors;
// the generalised form of the fixed 4-to-1 complex mux.
module mux_n_complex #(
  parameter  int WORD_SIZE = fft_pkg::WORD_SIZE_DEF,
  parameter  int N_CH      = 4,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic [N_CH*WORD_SIZE-1:0] in_re,
  input  logic [N_CH*WORD_SIZE-1:0] in_im,
  input  logic [SEL_W-1:0]          sel,
  output logic [WORD_SIZE-1:0]      out_re,
  output logic [WORD_SIZE-1:0]      out_im
);

  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    out_re = '0;
    out_im = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        out_re = in_re[k*WORD_SIZE +: WORD_SIZE];
        out_im = in_im[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/complex_frame_serializer.sv
// Captures a frame of N_CH complex samples and streams them one per accepted
// beat, in natural or bit-reversed channel order.
module complex_frame_serializer
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int N_CH      = 4
) (
  input logic                      clk,
  input logic                      rst,
  complex_frame_serializer_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          cnt_q;
  logic [SEL_W-1:0]          sel;
  logic [N_CH*WORD_SIZE-1:0] bank_re_q;
  logic [N_CH*WORD_SIZE-1:0] bank_im_q;
  logic                      bitrev_q;
  logic [WORD_SIZE-1:0]      mux_re;
  logic [WORD_SIZE-1:0]      mux_im;
  logic                      streaming;
  logic                      last_beat;
  logic                      beat_acc;
  logic                      in_ready;
  logic                      frame_acc;

  assign streaming = (state_q == STREAM);
  assign last_beat = streaming && (cnt_q == SEL_W'(N_CH - 1));
  assign beat_acc  = streaming && bus.out_ready;

  // Accepting a frame on the last-beat handshake keeps back-to-back frames bubble-free.
  assign in_ready     = !rst && (!streaming || (beat_acc && last_beat));
  assign frame_acc    = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_acc) state_d = STREAM;
      STREAM:  if (beat_acc && last_beat) state_d = frame_acc ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample bank, latched order mode and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bank is reset because a zeroed bank is part of the defined reset state.
      bank_re_q <= '0;
      bank_im_q <= '0;
      bitrev_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (frame_acc) begin
      bank_re_q <= bus.in_re;
      bank_im_q <= bus.in_im;
      bitrev_q  <= bus.bitrev;
      cnt_q     <= '0;
    end else if (beat_acc) begin
      cnt_q <= last_beat ? '0 : cnt_q + SEL_W'(1);
    end
  end

  assign sel = bitrev_q ? SEL_W'(bit_reverse(MAX_SEL_W'(cnt_q), SEL_W)) : cnt_q;

  mux_n_complex #(
    .WORD_SIZE (WORD_SIZE),
    .N_CH      (N_CH)
  ) u_mux (
    .in_re  (bank_re_q),
    .in_im  (bank_im_q),
    .sel    (sel),
    .out_re (mux_re),
    .out_im (mux_im)
  );

  // Output logic: beat fields are forced to zero whenever no beat is valid.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_re    = '0;
    bus.out_im    = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    if (streaming) begin
      bus.out_valid = 1'b1;
      bus.out_re    = mux_re;
      bus.out_im    = mux_im;
      bus.out_idx   = sel;
      bus.out_last  = last_beat;
    end
  end

endmodule

// File: tb/tb_complex_frame_serializer.sv
// Directed bench for complex_frame_serializer: a 4-channel and an 8-channel
// instance driven through their interfaces with hand-computed expectations.
module tb_complex_frame_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  complex_frame_serializer_if #(.WORD_SIZE(16), .N_CH(4)) bus4 ();
  complex_frame_serializer_if #(.WORD_SIZE(16), .N_CH(8)) bus8 ();

  complex_frame_serializer #(.WORD_SIZE(16), .N_CH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  complex_frame_serializer #(.WORD_SIZE(16), .N_CH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loads the 4-channel frame data: re = re_base + k*re_step, im likewise.
  task automatic load4(input int re_base, input int re_step,
                       input int im_base, input int im_step, input logic br);
    for (int k = 0; k < 4; k++) begin
      bus4.in_re[k*16 +: 16] = 16'(re_base + k*re_step);
      bus4.in_im[k*16 +: 16] = 16'(im_base + k*im_step);
    end
    bus4.bitrev = br;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({bus4.out_valid, bus4.in_ready, bus4.out_last, bus4.out_idx, bus4.out_re, bus4.out_im} !== '0 ||
        {bus8.out_valid, bus8.in_ready, bus8.out_last, bus8.out_idx, bus8.out_re, bus8.out_im} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v4=%0b rdy4=%0b re4=%0d v8=%0b rdy8=%0b re8=%0d, want all 0",
               bus4.out_valid, bus4.in_ready, bus4.out_re, bus8.out_valid, bus8.in_ready, bus8.out_re);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got rdy4=%0b v4=%0b rdy8=%0b, want rdy=1 v=0",
               bus4.in_ready, bus4.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_natural;
    int exp_re [4] = '{1, 2, 3, 4};
    int exp_im [4] = '{-1, -2, -3, -4};
    @(negedge clk);
    load4(1, 1, -1, -1, 1'b0);
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'(b) || bus4.out_re !== 16'(exp_re[b]) ||
          bus4.out_im !== 16'(exp_im[b]) || bus4.out_last !== (b == 3) || bus4.in_ready !== (b == 3)) begin
        failures++;
        $display("FAIL nat_beat%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b rdy=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b rdy=%0b",
                 b, bus4.out_valid, bus4.out_idx, $signed(bus4.out_re), $signed(bus4.out_im),
                 bus4.out_last, bus4.in_ready, b, exp_re[b], exp_im[b], b == 3, b == 3);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({bus4.out_valid, bus4.out_last, bus4.out_idx, bus4.out_re, bus4.out_im} !== '0) begin
      failures++;
      $display("FAIL nat_idle: got v=%0b idx=%0d re=%0d im=%0d last=%0b, want all 0",
               bus4.out_valid, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last);
    end
  endtask

  task automatic test_bitrev;
    int exp_idx [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int exp_re  [8] = '{0, 64, 32, 96, 16, 80, 48, 112};
    int exp_im  [8] = '{1000, 1004, 1002, 1006, 1001, 1005, 1003, 1007};
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      bus8.in_re[k*16 +: 16] = 16'(16*k);
      bus8.in_im[k*16 +: 16] = 16'(1000 + k);
    end
    bus8.bitrev    = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      #1;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_idx !== 3'(exp_idx[b]) || bus8.out_re !== 16'(exp_re[b]) ||
          bus8.out_im !== 16'(exp_im[b]) || bus8.out_last !== (b == 7)) begin
        failures++;
        $display("FAIL brev_beat%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b",
                 b, bus8.out_valid, bus8.out_idx, bus8.out_re, bus8.out_im, bus8.out_last,
                 exp_idx[b], exp_re[b], exp_im[b], b == 7);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL brev_idle: got v=%0b, want 0", bus8.out_valid);
    end
  endtask

  task automatic test_backpressure;
    int   beat = 0;
    int   cyc  = 0;
    logic rdy;
    @(negedge clk);
    load4(10, 1, 20, 1, 1'b0);
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    while (beat < 4 && cyc < 40) begin
      rdy = (cyc % 3 == 0);
      bus4.out_ready = rdy;
      #1;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'(beat) || bus4.out_re !== 16'(10 + beat) ||
          bus4.out_im !== 16'(20 + beat) || bus4.out_last !== (beat == 3) ||
          bus4.in_ready !== (rdy && beat == 3)) begin
        failures++;
        $display("FAIL bp_cyc%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b rdy=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b rdy=%0b",
                 cyc, bus4.out_valid, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last,
                 bus4.in_ready, beat, 10 + beat, 20 + beat, beat == 3, rdy && beat == 3);
      end
      if (rdy) beat++;
      cyc++;
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_extra_beat: got v=%0b, want 0", bus4.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int a_idx [4] = '{0, 2, 1, 3};
    @(negedge clk);
    load4(100, 1, 200, 1, 1'b1);
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin
        load4(300, 1, 400, 1, 1'b0);
        bus4.in_valid = 1'b1;
      end
      #1;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'(a_idx[b]) || bus4.out_re !== 16'(100 + a_idx[b]) ||
          bus4.out_im !== 16'(200 + a_idx[b]) || bus4.out_last !== (b == 3) || bus4.in_ready !== (b == 3)) begin
        failures++;
        $display("FAIL b2b_a_beat%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b rdy=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b rdy=%0b",
                 b, bus4.out_valid, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, bus4.in_ready,
                 a_idx[b], 100 + a_idx[b], 200 + a_idx[b], b == 3, b == 3);
      end
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'(b) || bus4.out_re !== 16'(300 + b) ||
          bus4.out_im !== 16'(400 + b) || bus4.out_last !== (b == 3)) begin
        failures++;
        $display("FAIL b2b_b_beat%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b",
                 b, bus4.out_valid, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last,
                 b, 300 + b, 400 + b, b == 3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_input;
    @(negedge clk);
    load4(500, 1, 600, 1, 1'b0);
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin
        load4(-7, 3, -9, 5, 1'b1);
        bus4.in_valid = 1'b1;
      end
      if (b == 3) bus4.in_valid = 1'b0;
      #1;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'(b) || bus4.out_re !== 16'(500 + b) ||
          bus4.out_im !== 16'(600 + b) || bus4.out_last !== (b == 3) || bus4.in_ready !== (b == 3)) begin
        failures++;
        $display("FAIL ign_beat%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b rdy=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b rdy=%0b",
                 b, bus4.out_valid, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, bus4.in_ready,
                 b, 500 + b, 600 + b, b == 3, b == 3);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ign_idle: got v=%0b, want 0", bus4.out_valid);
    end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    load4(700, 1, 800, 1, 1'b1);
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'd2 || bus4.out_re !== 16'd702) begin
      failures++;
      $display("FAIL rstmid_beat1: got v=%0b idx=%0d re=%0d, want v=1 idx=2 re=702",
               bus4.out_valid, bus4.out_idx, bus4.out_re);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus4.out_valid, bus4.in_ready, bus4.out_last, bus4.out_idx, bus4.out_re, bus4.out_im} !== '0) begin
      failures++;
      $display("FAIL rstmid_async: got v=%0b rdy=%0b idx=%0d re=%0d im=%0d last=%0b, want all 0",
               bus4.out_valid, bus4.in_ready, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_release: got rdy=%0b v=%0b, want rdy=1 v=0", bus4.in_ready, bus4.out_valid);
    end
    @(negedge clk);
    load4(900, 1, -5, -1, 1'b0);
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_idx !== 2'(b) || bus4.out_re !== 16'(900 + b) ||
          bus4.out_im !== 16'(-5 - b) || bus4.out_last !== (b == 3)) begin
        failures++;
        $display("FAIL rstmid_new_beat%0d: got v=%0b idx=%0d re=%0d im=%0d last=%0b, want v=1 idx=%0d re=%0d im=%0d last=%0b",
                 b, bus4.out_valid, bus4.out_idx, bus4.out_re, $signed(bus4.out_im), bus4.out_last,
                 b, 900 + b, -5 - b, b == 3);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    bus4.in_re     = '0;
    bus4.in_im     = '0;
    bus4.in_valid  = 1'b0;
    bus4.bitrev    = 1'b0;
    bus4.out_ready = 1'b0;
    bus8.in_re     = '0;
    bus8.in_im     = '0;
    bus8.in_valid  = 1'b0;
    bus8.bitrev    = 1'b0;
    bus8.out_ready = 1'b0;
    #1 rst = 1'b1;

    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
